// File: rtl/word_sync_tx.sv
// Source-side transmitter for a 4-phase req/ack word handshake across clock domains.
// Holds the captured word on data_out while req/ack completes; ack is synchronized locally.
module word_sync_tx #(
    parameter int P_DATA_WIDTH = 32,
    parameter int P_N_SYNC     = 2,
    parameter int P_TIMEOUT    = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr,
    input  logic [P_DATA_WIDTH-1:0] data_in,
    input  logic                    ack,
    output logic                    req,
    output logic [P_DATA_WIDTH-1:0] data_out,
    output logic                    busy,
    output logic                    done,
    output logic                    drop,
    output logic                    timeout
);

    localparam int LP_CW = (P_TIMEOUT > 0) ? $clog2(P_TIMEOUT + 1) : 1;
    localparam logic [LP_CW-1:0] LP_LAST = LP_CW'((P_TIMEOUT > 0) ? P_TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_REL
    } state_t;

    state_t                    r_state;
    logic                      r_wr_d;
    logic [P_N_SYNC-1:0]       r_sync;
    logic [LP_CW-1:0]          r_cnt;
    logic                      r_abort;
    logic                      r_req;
    logic [P_DATA_WIDTH-1:0]   r_data;
    logic                      r_done;
    logic                      r_drop;
    logic                      r_timeout;

    logic                      w_wr_pe;
    logic                      w_ack_s;
    logic                      w_tmo;
    logic [LP_CW-1:0]          w_cnt_inc;

    assign w_wr_pe   = wr & ~r_wr_d;
    assign w_ack_s   = r_sync[P_N_SYNC-1];
    assign w_tmo     = (P_TIMEOUT != 0) && (r_cnt == LP_LAST);
    assign w_cnt_inc = ((P_TIMEOUT != 0) && (r_cnt != '1)) ? r_cnt + 1'b1 : r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_d <= 1'b0;
            r_sync <= '0;
        end else begin
            r_wr_d <= wr;
            r_sync <= {r_sync[P_N_SYNC-2:0], ack};
        end
    end

    // After a REQ-phase timeout the receiver may still raise ack late, so the
    // release phase is waited out in full instead of completing on ack_s low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_abort   <= 1'b0;
            r_req     <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
            r_timeout <= 1'b0;
            if (w_wr_pe && (r_state != S_IDLE)) begin
                r_drop <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (w_wr_pe) begin
                        r_data  <= data_in;
                        r_req   <= 1'b1;
                        r_abort <= 1'b0;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_REL;
                    end else if (w_tmo) begin
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_abort   <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_REL;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                S_REL: begin
                    if (!w_ack_s && !r_abort) begin
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else if (w_tmo) begin
                        r_timeout <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req      = r_req;
    assign data_out = r_data;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign drop     = r_drop;
    assign timeout  = r_timeout;

endmodule
